// File: rtl/sqa_arbiter_if.sv
// Bundles the requester, squarer and result-slot signals of the sqa_arbiter.
// slave is the arbiter's view; master is the environment driving it.
interface sqa_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int CH_WIDTH   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]            req_in;
    logic [NUM_CH*DATA_WIDTH-1:0] stan_dev_in;
    logic [NUM_CH*DATA_WIDTH-1:0] avg_in;
    logic [NUM_CH-1:0]            gnt_out;
    logic [DATA_WIDTH-1:0]        sq_stan_dev;
    logic [DATA_WIDTH-1:0]        sq_avg;
    logic                         sq_valid;
    logic [DATA_WIDTH-1:0]        sq_var_in;
    logic [DATA_WIDTH-1:0]        sq_avg_in;
    logic                         sq_valid_in;
    logic                         valid_out;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        var_out;
    logic [DATA_WIDTH-1:0]        avg_out;
    logic [CH_WIDTH-1:0]          ch_out;
    logic                         batch_done;

    modport slave (
        input  req_in, stan_dev_in, avg_in, sq_var_in, sq_avg_in, sq_valid_in, out_ready,
        output gnt_out, sq_stan_dev, sq_avg, sq_valid, valid_out, var_out, avg_out,
               ch_out, batch_done
    );

    modport master (
        output req_in, stan_dev_in, avg_in, sq_var_in, sq_avg_in, sq_valid_in, out_ready,
        input  gnt_out, sq_stan_dev, sq_avg, sq_valid, valid_out, var_out, avg_out,
               ch_out, batch_done
    );
endinterface

// File: rtl/sqa_arbiter.sv
// Round-robin share of one squarer among NUM_CH channels, with a one-deep
// tagged result slot and a mini-batch completion pulse.
module sqa_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int CH_WIDTH   = $clog2(NUM_CH),
    parameter int MINI_BATCH = 64,
    parameter int ADDR_WIDTH = $clog2(MINI_BATCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    sqa_arbiter_if.slave   bus
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CH_WIDTH-1:0]   last_q, last_d;
    logic [DATA_WIDTH-1:0] var_q, var_d;
    logic [DATA_WIDTH-1:0] avg_q, avg_d;
    logic [CH_WIDTH-1:0]   ch_q, ch_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  batch_done_q, batch_done_d;

    logic                  found;
    logic [CH_WIDTH-1:0]   win;
    logic                  slot_free;
    logic                  grant;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] sel_stan_dev;
    logic [DATA_WIDTH-1:0] sel_avg;

    assign slot_free = (state_q == EMPTY) || bus.out_ready;
    assign xfer      = (state_q == FULL) && bus.out_ready;
    assign grant     = slot_free && found;

    // Search starts one past the last winner so a busy channel cannot starve others.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int idx;
            idx = (int'(last_q) + k) % NUM_CH;
            if (!found && bus.req_in[idx]) begin
                found = 1'b1;
                win   = CH_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        sel_stan_dev = '0;
        sel_avg      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant && win == CH_WIDTH'(i)) begin
                sel_stan_dev = bus.stan_dev_in[i*DATA_WIDTH +: DATA_WIDTH];
                sel_avg      = bus.avg_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            bus.gnt_out[i] = grant && (win == CH_WIDTH'(i));
        end
    end

    assign bus.sq_stan_dev = sel_stan_dev;
    assign bus.sq_avg      = sel_avg;
    assign bus.sq_valid    = grant;

    // A grant always refills the slot, even when the old result leaves on the same edge.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        var_d        = var_q;
        avg_d        = avg_q;
        ch_d         = ch_q;
        cnt_d        = cnt_q;
        batch_done_d = 1'b0;

        if (grant) begin
            state_d = FULL;
            last_d  = win;
            var_d   = bus.sq_var_in;
            avg_d   = bus.sq_avg_in;
            ch_d    = win;
        end else if (xfer) begin
            state_d = EMPTY;
        end

        if (xfer) begin
            if (cnt_q == ADDR_WIDTH'(MINI_BATCH - 1)) begin
                cnt_d        = '0;
                batch_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            last_q       <= CH_WIDTH'(NUM_CH - 1);
            var_q        <= '0;
            avg_q        <= '0;
            ch_q         <= '0;
            cnt_q        <= '0;
            batch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            var_q        <= var_d;
            avg_q        <= avg_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            batch_done_q <= batch_done_d;
        end
    end

    assign bus.valid_out  = (state_q == FULL);
    assign bus.var_out    = var_q;
    assign bus.avg_out    = avg_q;
    assign bus.ch_out     = ch_q;
    assign bus.batch_done = batch_done_q;
endmodule

// File: tb/tb_sqa_arbiter.sv
// Directed bench for sqa_arbiter with a behavioural squarer attached.
module tb_sqa_arbiter;
    localparam int DW = 16;
    localparam int NC = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sqa_arbiter_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

    sqa_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NC), .MINI_BATCH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Combinational squarer: low DW bits of the signed square
    logic signed [2*DW-1:0] prod;
    assign prod            = $signed(bus.sq_stan_dev) * $signed(bus.sq_stan_dev);
    assign bus.sq_var_in   = prod[DW-1:0];
    assign bus.sq_avg_in   = bus.sq_avg;
    assign bus.sq_valid_in = bus.sq_valid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NC-1:0] req, input logic ready);
        bus.req_in    = req;
        bus.out_ready = ready;
    endtask

    task automatic setChannel(input int ch, input logic [DW-1:0] sd, input logic [DW-1:0] av);
        bus.stan_dev_in[ch*DW +: DW] = sd;
        bus.avg_in[ch*DW +: DW]      = av;
    endtask

    task automatic doReset();
        applyStimulus('0, 1'b1);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        bus.stan_dev_in = '0;
        bus.avg_in      = '0;
        applyStimulus('0, 1'b1);
        rst_n = 1'b0;
        step();
        step();

        checkOutput("rst_valid", 32'(bus.valid_out), 0);
        checkOutput("rst_var", 32'(bus.var_out), 0);
        checkOutput("rst_avg", 32'(bus.avg_out), 0);
        checkOutput("rst_ch", 32'(bus.ch_out), 0);
        checkOutput("rst_batch", 32'(bus.batch_done), 0);
        checkOutput("rst_gnt", 32'(bus.gnt_out), 0);
        checkOutput("rst_sqvalid", 32'(bus.sq_valid), 0);
        rst_n = 1'b1;
        step();

        // Single request from channel 2
        setChannel(2, -16'sd3, 16'd5);
        applyStimulus(4'b0100, 1'b1);
        #1;
        checkOutput("single_gnt", 32'(bus.gnt_out), 32'h4);
        checkOutput("single_sqsd", 32'(bus.sq_stan_dev), 32'hFFFD);
        checkOutput("single_sqvalid", 32'(bus.sq_valid), 1);
        step();
        applyStimulus('0, 1'b1);
        #1;
        checkOutput("single_valid", 32'(bus.valid_out), 1);
        checkOutput("single_var", 32'(bus.var_out), 9);
        checkOutput("single_avg", 32'(bus.avg_out), 5);
        checkOutput("single_ch", 32'(bus.ch_out), 2);
        checkOutput("single_nognt", 32'(bus.gnt_out), 0);

        // Asynchronous reset while FULL
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(bus.valid_out), 0);
        checkOutput("midrst_var", 32'(bus.var_out), 0);
        checkOutput("midrst_batch", 32'(bus.batch_done), 0);
        rst_n = 1'b1;

        // All channels request: ch i operand i+1, average 10*i
        for (int i = 0; i < NC; i++) setChannel(i, DW'(i + 1), DW'(10 * i));
        applyStimulus(4'b1111, 1'b1);
        #1;
        for (int k = 0; k < 6; k++) begin
            checkOutput("rr_gnt", 32'(bus.gnt_out), 32'(1 << (k % 4)));
            if (k > 0) begin
                checkOutput("rr_ch", 32'(bus.ch_out), 32'((k - 1) % 4));
                checkOutput("rr_var", 32'(bus.var_out), 32'((((k - 1) % 4) + 1) * (((k - 1) % 4) + 1)));
                checkOutput("rr_avg", 32'(bus.avg_out), 32'(10 * ((k - 1) % 4)));
            end
            step();
        end

        // Backpressure with ch1 (var 4, avg 10) held in the slot
        applyStimulus(4'b1111, 1'b0);
        #1;
        for (int c = 0; c < 3; c++) begin
            checkOutput("bp_gnt", 32'(bus.gnt_out), 0);
            checkOutput("bp_valid", 32'(bus.valid_out), 1);
            checkOutput("bp_ch", 32'(bus.ch_out), 1);
            checkOutput("bp_var", 32'(bus.var_out), 4);
            checkOutput("bp_avg", 32'(bus.avg_out), 10);
            step();
        end
        applyStimulus(4'b1111, 1'b1);
        #1;
        checkOutput("bp_release_gnt", 32'(bus.gnt_out), 32'h4);
        step();
        checkOutput("bp_release_ch", 32'(bus.ch_out), 2);
        checkOutput("bp_release_var", 32'(bus.var_out), 9);
        checkOutput("bp_release_valid", 32'(bus.valid_out), 1);

        // Overflow: 300*300 = 90000, low 16 bits = 24464
        doReset();
        setChannel(0, 16'd300, 16'd7);
        applyStimulus(4'b0001, 1'b1);
        step();
        applyStimulus('0, 1'b1);
        #1;
        checkOutput("ovf_var", 32'(bus.var_out), 24464);
        checkOutput("ovf_avg", 32'(bus.avg_out), 7);

        // Batch: after the n-th edge, n-1 transfers have completed
        doReset();
        applyStimulus(4'b0001, 1'b1);
        for (int n = 1; n <= 130; n++) begin
            step();
            checkOutput($sformatf("batch_%0d", n), 32'(bus.batch_done),
                        32'((n == 65) || (n == 129)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sqa_arbiter.md
# sqa_arbiter

Round-robin scheduler that shares one `sqa` square unit among `NUM_CH` batch-norm channel requesters. It grants at most one requester per cycle and drives the winner's standard deviation and average into the combinational squarer. It registers the squarer's result into a one-deep output slot tagged with the channel ID, and counts delivered results to flag each completed mini-batch.

## Interface
Parameters:
- `DATA_WIDTH`, 16, operand and result width
- `NUM_CH`, 4, number of requesting channels (≥2)
- `CH_WIDTH`, `$clog2(NUM_CH)`, channel-ID width
- `MINI_BATCH`, 64, results per batch
- `ADDR_WIDTH`, `$clog2(MINI_BATCH)`, batch counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_in`  in  `NUM_CH`  per-channel request, bit i = channel i
- `stan_dev_in`  in  `NUM_CH*DATA_WIDTH`  signed operands, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `avg_in`  in  `NUM_CH*DATA_WIDTH`  signed averages, same packing
- `gnt_out`  out  `NUM_CH`  one-hot grant, combinational
- `sq_stan_dev`  out  `DATA_WIDTH`  operand to squarer
- `sq_avg`  out  `DATA_WIDTH`  average to squarer
- `sq_valid`  out  1  squarer valid_in
- `sq_var_in`  in  `DATA_WIDTH`  squarer var_out
- `sq_avg_in`  in  `DATA_WIDTH`  squarer avg_out
- `sq_valid_in`  in  1  squarer valid_out
- `valid_out`  out  1  output slot holds a result
- `out_ready`  in  1  downstream accepts the result
- `var_out`  out  `DATA_WIDTH`  registered square
- `avg_out`  out  `DATA_WIDTH`  registered average
- `ch_out`  out  `CH_WIDTH`  channel that produced the result
- `batch_done`  out  1  one-cycle pulse per `MINI_BATCH` delivered results

## Operation
- Output slot FSM:
  - EMPTY: `valid_out`=0.
  - FULL: `valid_out`=1.
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on `valid_out & out_ready` with no grant.
  - FULL stays FULL on a transfer with a simultaneous grant.
- `slot_free` = EMPTY | (FULL & `out_ready`). A grant is issued only when `slot_free` is 1 and `req_in` is nonzero.
- Arbitration:
  - Round-robin pointer `last` holds the last granted channel.
  - Search order is `last+1`, `last+2`, …, wrapping modulo `NUM_CH`. The first asserted request wins.
  - `last` updates to the winner on each grant.
  - Reset value of `last` is `NUM_CH-1`, so channel 0 has first priority.
- Squarer drive:
  - `sq_valid` = grant.
  - `sq_stan_dev`/`sq_avg` carry the winner's slice; both are 0 when there is no grant.
- Capture: on a grant, the edge loads `var_out`←`sq_var_in`, `avg_out`←`sq_avg_in` and `ch_out`←winner index. `sq_valid_in` low at a grant is an integration error and still loads.
- Arithmetic: the square is the low `DATA_WIDTH` bits of the signed product, as produced by the squarer. No saturation is applied here.
- Requester handshake:
  - Hold `req` and operands stable until `gnt` is sampled high.
  - The transfer completes on that edge.
  - Keeping `req` high requests another item; round-robin keeps one channel from starving the others.
- Batch counter:
  - Increments on each `valid_out & out_ready`.
  - On the transfer that takes it from `MINI_BATCH-1` it wraps to 0 and `batch_done` is registered high for the next cycle.
- Reset (async, any time): slot EMPTY, `last`=`NUM_CH-1`, counter 0. Any held result is discarded.

## Timing
- Reset values:
  - `valid_out`=0, `var_out`=0, `avg_out`=0, `ch_out`=0, `batch_done`=0.
  - `gnt_out`=0, `sq_valid`=0, since the slot is EMPTY and there are no requests.
- Latency: grant in cycle N, result visible on `valid_out`/`var_out` in cycle N+1.
- Throughput: 1 result/cycle with `out_ready` held high.
- Backpressure: while FULL and `out_ready`=0, `gnt_out`=0 and the outputs hold stable.
- `gnt_out` and `sq_*` are combinational from `req_in`, slot state and `out_ready`. There is no combinational path from `sq_*_in` to any output.
- `batch_done` is high exactly 1 cycle, in the cycle after the terminal transfer.

## Test plan
- Reset mid-operation: pulse `rst_n` low while FULL with `var_out`=9 → `valid_out`, `var_out` and `batch_done` go 0 immediately; the first post-reset grant goes to ch0.
- Single request: ch2 `stan_dev`=-3, `avg`=5, `req`=4'b0100, `out_ready`=1 → `gnt_out`=4'b0100 same cycle; next cycle `valid_out`=1, `var_out`=9, `avg_out`=5, `ch_out`=2.
- All four channels request continuously → grants 0,1,2,3,0,… on consecutive cycles; `ch_out` follows one cycle later.
- Backpressure: `out_ready`=0 for 3 cycles while FULL → no grants, outputs stable; `out_ready`=1 → transfer and a new grant in the same cycle.
- Overflow: `stan_dev`=300 → `var_out`=16'd24464 (90000 mod 65536).
- Batch: 64 accepted transfers → `batch_done` high only in the cycle after the 64th; the 65th–128th transfers produce the second pulse.
